// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor (addsub_pipe).
// Holds the default geometry, the chunk-width helper, a one-bit full adder
// used by the chunk ripple, and the per-stage control portion of a beat.
package addsub_pkg;

    localparam int unsigned ADDSUB_DEF_WIDTH  = 16;
    localparam int unsigned ADDSUB_DEF_STAGES = 4;

    // Width of one pipeline chunk; zero stages yields zero so the caller can flag it.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : (width / stages);
    endfunction

    // One-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic a,
                                              input logic b,
                                              input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
        return {co, s};
    endfunction

    // Control fields carried alongside each beat; operand and partial-sum
    // vectors are WIDTH-dependent and live next to this in each stage.
    typedef struct packed {
        logic valid;   // stage holds a live beat
        logic sub;     // beat is a subtraction
        logic sgn;     // signed overflow/saturation rules
        logic carry;   // carry out of the most recently added chunk
        logic cmsb;    // carry into the MSB of that chunk
        logic a_msb;   // sign of operand A, used to pick the saturation rail
    } beat_ctrl_t;

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry adder slice for addsub_pipe.
// Returns the sum chunk, the carry out of its MSB and the carry into its MSB
// (the latter two give the signed overflow flag in the final stage).
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    // Ripple the carry bit by bit through the chunk.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            {c[i+1], sum[i]} = full_adder(a[i], b[i], c[i]);
        end
        cout = c[CHUNK];
        cmsb = c[CHUNK-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with elastic valid/ready.
// The operand is split into STAGES chunks; stage k adds chunk k with the
// carry registered by stage k-1. Unconsumed operand chunks and finished sum
// chunks ride along with the beat. Flags (and optional saturation) are
// derived from the final stage register.
// Optional feature: define ADDSUB_SAT_EN to saturate out_sum on overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = ADDSUB_DEF_WIDTH,
    parameter int unsigned STAGES = ADDSUB_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int unsigned SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;

    if ((STAGES < 1) || (CHUNK < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // Per-stage register views, indexed by stage.
    beat_ctrl_t       st_ctrl [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_sum  [STAGES];
    logic [STAGES-1:0] st_vld;
    logic [STAGES:0]   ready;

    // Backpressure chain: a stage can load when empty or when it drains this cycle.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            ready[STAGES-1-i] = !st_vld[STAGES-1-i] | ready[STAGES-i];
        end
    end

    assign in_ready = ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        beat_ctrl_t       ctrl_up;
        logic [WIDTH-1:0] a_up;
        logic [WIDTH-1:0] b_up;
        logic [WIDTH-1:0] sum_up;
        logic [CHUNK-1:0] sum_chunk;
        logic             c_out;
        logic             c_msb;

        beat_ctrl_t       ctrl_q, ctrl_d;
        logic [WIDTH-1:0] a_q, a_d;
        logic [WIDTH-1:0] b_q, b_d;
        logic [WIDTH-1:0] sum_q, sum_d;

        if (k == 0) begin : g_src_in
            // Subtraction folds into addition of ~B with carry-in ~cin (cin is a borrow).
            assign a_up          = in_a;
            assign b_up          = in_sub ? ~in_b : in_b;
            assign sum_up        = '0;
            assign ctrl_up.valid = in_valid;
            assign ctrl_up.sub   = in_sub;
            assign ctrl_up.sgn   = in_signed;
            assign ctrl_up.carry = in_sub ? ~in_cin : in_cin;
            assign ctrl_up.cmsb  = 1'b0;
            assign ctrl_up.a_msb = in_a[WIDTH-1];
        end else begin : g_src_stage
            assign a_up    = st_a[k-1];
            assign b_up    = st_b[k-1];
            assign sum_up  = st_sum[k-1];
            assign ctrl_up = st_ctrl[k-1];
        end

        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (a_up[k*CHUNK +: CHUNK]),
            .b    (b_up[k*CHUNK +: CHUNK]),
            .cin  (ctrl_up.carry),
            .sum  (sum_chunk),
            .cout (c_out),
            .cmsb (c_msb)
        );

        // Next-state for this stage: hold on stall, otherwise take the upstream beat with chunk k filled in.
        always_comb begin
            ctrl_d = ctrl_q;
            a_d    = a_q;
            b_d    = b_q;
            sum_d  = sum_q;
            if (ready[k]) begin
                ctrl_d.valid = ctrl_up.valid;
                if (ctrl_up.valid) begin
                    ctrl_d                     = ctrl_up;
                    ctrl_d.carry               = c_out;
                    ctrl_d.cmsb                = c_msb;
                    a_d                        = a_up;
                    b_d                        = b_up;
                    sum_d                      = sum_up;
                    sum_d[k*CHUNK +: CHUNK]    = sum_chunk;
                end
            end
        end

        // Stage register; reset empties the stage and clears its payload.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctrl_q <= '0;
                a_q    <= '0;
                b_q    <= '0;
                sum_q  <= '0;
            end else begin
                ctrl_q <= ctrl_d;
                a_q    <= a_d;
                b_q    <= b_d;
                sum_q  <= sum_d;
            end
        end

        assign st_ctrl[k] = ctrl_q;
        assign st_a[k]    = a_q;
        assign st_b[k]    = b_q;
        assign st_sum[k]  = sum_q;
        assign st_vld[k]  = ctrl_q.valid;
    end

    beat_ctrl_t last;
    logic       ovf_v;

    assign last = st_ctrl[STAGES-1];

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_SMIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_SMAX = ~SAT_SMIN;
`endif

    // Result flags from the final stage, plus the optional saturating clamp.
    always_comb begin
        out_valid = last.valid;
        out_cout  = last.carry;
        ovf_v     = last.carry ^ last.cmsb;
        out_ovf   = last.sgn ? ovf_v : (last.sub ? ~last.carry : last.carry);
        out_sum   = st_sum[STAGES-1];
`ifdef ADDSUB_SAT_EN
        if (out_ovf) begin
            if (last.sgn) begin
                out_sum = last.a_msb ? SAT_SMIN : SAT_SMAX;
            end else begin
                out_sum = last.sub ? '0 : '1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, STAGES=4).
// Expected results come from a plain-integer reference model applied to each
// accepted beat and kept in an in-order queue.
module tb_addsub_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_sub;
    logic          in_cin;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    addsub_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          n_out = 0;
    res_t        exp_q[$];
    int unsigned out_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer arithmetic, then wrap/flag/saturate by the rules.
    function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input logic cin, input logic sgn);
        res_t   r;
        longint ua, ub, u, sa, sb, t;
        logic   v;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        u  = sub ? (ua - ub - cin) : (ua + ub + cin);
        t  = sub ? (sa - sb - cin) : (sa + sb + cin);
        r.sum  = u[15:0];
        r.cout = sub ? (u >= 0) : (u > 65535);
        v      = (t > 32767) || (t < -32768);
        r.ovf  = sgn ? v : (sub ? (u < 0) : (u > 65535));
`ifdef ADDSUB_SAT_EN
        if (r.ovf) r.sum = sgn ? ((t > 0) ? 16'h7FFF : 16'h8000) : (sub ? 16'h0000 : 16'hFFFF);
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst && in_valid && in_ready)
            exp_q.push_back(ref_op(in_a, in_b, in_sub, in_cin, in_signed));
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst && out_valid && out_ready) begin
            chk("out_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_sum",  {16'b0, out_sum}, {16'b0, e.sum});
                chk("sb_cout", {31'b0, out_cout}, {31'b0, e.cout});
                chk("sb_ovf",  {31'b0, out_ovf}, {31'b0, e.ovf});
                out_cyc.push_back(cyc);
                n_out++;
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input logic sgn);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        in_signed = sgn;
    endtask

    task automatic drive_rand();
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One beat on an idle pipe: check latency and the result against given constants.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic cin, input logic sgn,
                           input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        drive(a, b, sub, cin, sgn);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  lat, S);
        chk({tag, "_sum"},  {16'b0, out_sum}, {16'b0, es});
        chk({tag, "_cout"}, {31'b0, out_cout}, {31'b0, ec});
        chk({tag, "_ovf"},  {31'b0, out_ovf}, {31'b0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        int          base_n, base_c, sent;
        logic        prev_stall, drop_seen, acc;
        logic [15:0] h_sum;
        logic        h_cout, h_ovf;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; in_signed = 1'b0;
        #12 rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum",   {16'b0, out_sum}, 32'd0);
        chk("rst_out_cout",  {31'b0, out_cout}, 32'd0);
        chk("rst_out_ovf",   {31'b0, out_ovf}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed vectors
        run_one("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        run_one("usub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_one("sadd_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_one("sadd_neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        run_one("usub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        run_one("sadd_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_one("sadd_neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        run_one("usub_cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);

        // 20 back-to-back random beats
        base_n = n_out;
        base_c = out_cyc.size();
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("stream_count", n_out - base_n, 20);
        if (out_cyc.size() >= base_c + 20)
            chk("stream_back_to_back", out_cyc[base_c+19] - out_cyc[base_c], 19);

        // Stream with a 6-cycle output stall
        base_n     = n_out;
        sent       = 0;
        prev_stall = 1'b0;
        drop_seen  = 1'b0;
        h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c < 9);
            if (sent < 16) drive_rand();
            else in_valid = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_sum",   {16'b0, out_sum}, {16'b0, h_sum});
                chk("stall_cout",  {31'b0, out_cout}, {31'b0, h_cout});
                chk("stall_ovf",   {31'b0, out_ovf}, {31'b0, h_ovf});
            end
            prev_stall = out_valid && !out_ready;
            h_sum = out_sum; h_cout = out_cout; h_ovf = out_ovf;
            if (!in_ready && !drop_seen) begin
                drop_seen = 1'b1;
                chk("inflight_at_drop", exp_q.size(), S);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_in_ready_dropped", {31'b0, drop_seen}, 32'd1);
        chk("stall_sent", sent, 16);
        chk("stall_delivered", n_out - base_n, 16);
        chk("stall_drained", exp_q.size(), 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_out_sum",   {16'b0, out_sum}, 32'd0);
        chk("midrst_out_ovf",   {31'b0, out_ovf}, 32'd0);
        chk("midrst_in_ready",  {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        base_n = n_out;
        #10 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale_beat", {31'b0, out_valid}, 32'd0);
        end
        chk("no_stale_count", n_out - base_n, 0);

        // Pipe still works after reset
        @(posedge clk); #1;
        run_one("post_rst_add", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0,
`ifdef ADDSUB_SAT_EN
                16'hFFFF,
`else
                16'h0000,
`endif
                1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
